// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, oversampling ratio and the baud divider helper.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } uart_rx_state_t;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int uart_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick on the wrap cycle.
// A synchronous clear realigns the phase, e.g. to a start edge.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN) deserializer using 16x oversampled
// mid-bit sampling, with a valid/ready holding register and framing/overrun reporting.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_error,
    output logic       rx_overrun
);

    import uart_pkg::*;

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic           rx_meta;
    logic           rx_sync;
    logic           tick;
    logic           tick_clear;
    uart_rx_state_t state;
    logic [3:0]     sample_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
`ifdef UART_RX_PARITY_EN
    logic           parity_err;
`endif

    // Reset to 1 so an idle line is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    // Holding the divider cleared while idle lines its phase up with the start edge.
    assign tick_clear = (state == ST_IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(tick_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (!rx_sync) begin
                        state <= ST_START;
                    end
                end

                // A start bit that is gone by mid-bit was a glitch; drop it silently.
                ST_START: begin
                    if (tick) begin
                        if (sample_cnt == 4'd7) begin
                            sample_cnt <= '0;
                            state      <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == 4'd15) begin
                            shift_reg <= {rx_sync, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == 4'd15) begin
                            parity_err <= rx_sync ^ (^shift_reg);
                            state      <= ST_STOP;
                        end
                    end
                end
`endif

                // A low stop bit may be the start of a break, so wait for the line to recover.
                ST_STOP: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == 4'd15) begin
                            if (!rx_sync) begin
                                rx_error <= 1'b1;
                                state    <= ST_WAIT_IDLE;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (parity_err) begin
                                rx_error <= 1'b1;
                                state    <= ST_IDLE;
                            end
`endif
                            else begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift_reg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    rx_overrun <= 1'b1;
                                end
                                state <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx at a fast baud setting (4 clocks per tick, 64 per bit).
// Build with +define+UART_RX_PARITY_EN to exercise the parity frame and its error path.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 25_000;
    localparam int DIV      = 4;
    localparam int BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_error;
    logic       rx_overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = 0;
    int         acc_cnt = 0;
    int         rise_cnt = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         acc0, rise0, err0, ovr0;
    logic       prev_valid = 1'b0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_error  (rx_error),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(50_000 * 10);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: every accepted byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = rx_valid;
        if (rx_error)   err_cnt++;
        if (rx_overrun) ovr_cnt++;
        if (rx_valid && rx_ready) begin
            acc_cnt++;
            checkOutput("scoreboard_not_empty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic snap();
        acc0  = acc_cnt;
        rise0 = rise_cnt;
        err0  = err_cnt;
        ovr0  = ovr_cnt;
    endtask

    task automatic idleBits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Drives one whole frame, starting and ending on a falling clock edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        start_cyc = cyc;
        rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par_bit;
        repeat (BIT) @(negedge clk);
`else
        if (par_bit === 1'bx) rx_in = 1'b1;
`endif
        rx_in = stop_bit;
        repeat (BIT) @(negedge clk);
        rx_in = 1'b1;
    endtask

    initial begin
        logic [7:0] b;

        repeat (4) @(negedge clk);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_error", 32'(rx_error), 32'd0);
        checkOutput("reset_rx_overrun", 32'(rx_overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte with the consumer always ready; valid rises 2 + 9.5 bits after the edge, +-1 tick.
        snap();
        exp_q.push_back(8'h42);
        applyStimulus(8'h42, 1'b1, even_par(8'h42));
        idleBits(2);
        checkOutput("byte42_latency_window",
                    32'((rise_cyc - start_cyc) >= 2 + BIT * 19 / 2 - DIV &&
                        (rise_cyc - start_cyc) <= 2 + BIT * 19 / 2 + DIV), 32'd1);
        checkOutput("byte42_accepted", 32'(acc_cnt - acc0), 32'd1);
        checkOutput("byte42_valid_rises", 32'(rise_cnt - rise0), 32'd1);
        checkOutput("byte42_no_error", 32'(err_cnt - err0), 32'd0);
        checkOutput("byte42_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

        // Consumer stalled: the first byte is held and the second overruns.
        snap();
        rx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1, even_par(8'hA5));
        idleBits(1);
        applyStimulus(8'h3C, 1'b1, even_par(8'h3C));
        idleBits(1);
        checkOutput("ovr_count", 32'(ovr_cnt - ovr0), 32'd1);
        checkOutput("ovr_held_data", 32'(rx_data), 32'hA5);
        checkOutput("ovr_held_valid", 32'(rx_valid), 32'd1);
        checkOutput("ovr_no_error", 32'(err_cnt - err0), 32'd0);
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("ovr_drain_accepted", 32'(acc_cnt - acc0), 32'd1);
        checkOutput("ovr_drain_valid_clear", 32'(rx_valid), 32'd0);

        // Framing error followed by a long break gives a single error, then normal reception.
        snap();
        applyStimulus(8'h55, 1'b0, even_par(8'h55));
        rx_in = 1'b0;
        repeat (3 * FRAME_BITS * BIT) @(negedge clk);
        idleBits(2);
        checkOutput("break_single_error", 32'(err_cnt - err0), 32'd1);
        checkOutput("break_no_valid", 32'(rise_cnt - rise0), 32'd0);
        exp_q.push_back(8'h81);
        applyStimulus(8'h81, 1'b1, even_par(8'h81));
        idleBits(2);
        checkOutput("after_break_accepted", 32'(acc_cnt - acc0), 32'd1);

        // Short low glitch on an idle line.
        snap();
        rx_in = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        idleBits(2);
        checkOutput("glitch_no_valid", 32'(rise_cnt - rise0), 32'd0);
        checkOutput("glitch_no_error", 32'(err_cnt - err0), 32'd0);
        checkOutput("glitch_state_idle", 32'(dut.state), 32'(uart_pkg::ST_IDLE));

        // Reset in the middle of bit 3 of 0xFF; only the following byte may appear.
        snap();
        rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT / 2 - 3) @(negedge clk);
        idleBits(FRAME_BITS - 4);
        checkOutput("rst_mid_no_valid", 32'(rise_cnt - rise0), 32'd0);
        checkOutput("rst_mid_state_idle", 32'(dut.state), 32'(uart_pkg::ST_IDLE));
        exp_q.push_back(8'h12);
        applyStimulus(8'h12, 1'b1, even_par(8'h12));
        idleBits(2);
        checkOutput("rst_mid_then_12", 32'(acc_cnt - acc0), 32'd1);
        checkOutput("rst_mid_no_error", 32'(err_cnt - err0), 32'd0);

        // A few random bytes back to back.
        snap();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            applyStimulus(b, 1'b1, even_par(b));
            idleBits(1);
        end
        checkOutput("random_accepted", 32'(acc_cnt - acc0), 32'd4);
        checkOutput("random_no_error", 32'(err_cnt - err0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        snap();
        exp_q.push_back(8'h07);
        applyStimulus(8'h07, 1'b1, 1'b1);
        idleBits(2);
        checkOutput("parity_good_accepted", 32'(acc_cnt - acc0), 32'd1);
        checkOutput("parity_good_no_error", 32'(err_cnt - err0), 32'd0);
        snap();
        applyStimulus(8'h07, 1'b1, 1'b0);
        idleBits(2);
        checkOutput("parity_bad_error", 32'(err_cnt - err0), 32'd1);
        checkOutput("parity_bad_no_valid", 32'(rise_cnt - rise0), 32'd0);
`endif

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
